bcd_scan_display: RTL and testbench

- Downstream consumer of the 4-digit cascaded decimal counter: time-multiplexes four BCD digits (q0..q3) onto one 7-segment bus plus four digit-anode lines.
- Contains a refresh prescaler, a digit-slot rotator, a frame-synchronous input snapshot (no tearing while the counter runs), leading-zero blanking and registered segment/anode outputs.

---
 rtl/bcd_scan_display.sv | 115 +++++++++++
 tb/tb_bcd_scan_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Four-digit BCD multiplexed 7-segment driver with frame snapshot and
// leading-zero blanking; outputs registered, polarity set by parameters.
module bcd_scan_display #(
    parameter int PRESCALE       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rn,
    input  logic       ce,
    input  logic       blank_lz,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dp,
    output logic [6:0] seg,
    output logic       dpo,
    output logic [3:0] an,
    output logic       frame
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CMAX = CW'(PRESCALE - 1);

    logic [CW-1:0]     cnt;
    logic [1:0]        slot;
    logic [3:0][3:0]   snap;
    logic [3:0]        sdp;
    logic              tick;
    logic [3:0]        cur;
    logic              blank;
    logic [6:0]        dec;
    logic [6:0]        seg_n;
    logic [3:0]        an_n;

    assign tick  = ce & (cnt == CMAX);
    assign frame = tick & (slot == 2'd3);

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            cnt <= '0;
        end else if (ce) begin
            cnt <= (cnt == CMAX) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            slot <= 2'd0;
        end else if (tick) begin
            slot <= slot + 2'd1;
        end
    end

    // Inputs are sampled only at the frame boundary so a running
    // counter never tears across the four digits of one frame.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            snap <= '0;
            sdp  <= '0;
        end else if (frame) begin
            snap <= {d3, d2, d1, d0};
            sdp  <= dp;
        end
    end

    assign cur = snap[slot];

    always_comb begin
        blank = 1'b0;
        unique case (slot)
            2'd3: blank = blank_lz & (snap[3] == 4'd0);
            2'd2: blank = blank_lz & (snap[3] == 4'd0)
                                   & (snap[2] == 4'd0);
            2'd1: blank = blank_lz & (snap[3] == 4'd0)
                                   & (snap[2] == 4'd0)
                                   & (snap[1] == 4'd0);
            2'd0: blank = 1'b0;
        endcase
    end

    always_comb begin
        dec = 7'h40;
        unique case (cur)
            4'd0:    dec = 7'h3F;
            4'd1:    dec = 7'h06;
            4'd2:    dec = 7'h5B;
            4'd3:    dec = 7'h4F;
            4'd4:    dec = 7'h66;
            4'd5:    dec = 7'h6D;
            4'd6:    dec = 7'h7D;
            4'd7:    dec = 7'h07;
            4'd8:    dec = 7'h7F;
            4'd9:    dec = 7'h6F;
            default: dec = 7'h40;
        endcase
    end

    assign seg_n = blank ? 7'h00 : dec;
    assign an_n  = 4'b0001 << slot;

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            seg <= {7{SEG_ACTIVE_LOW}};
            dpo <= SEG_ACTIVE_LOW;
            an  <= {4{AN_ACTIVE_LOW}};
        end else if (ce) begin
            seg <= seg_n ^ {7{SEG_ACTIVE_LOW}};
            dpo <= sdp[slot] ^ SEG_ACTIVE_LOW;
            an  <= an_n ^ {4{AN_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized scoreboard bench for bcd_scan_display against a
// cycle-count based reference model.
module tb_bcd_scan_display;

    localparam int P = 4;
    localparam int FR = 4 * P;

    logic       clk = 1'b0;
    logic       rn = 1'b0;
    logic       ce = 1'b0;
    logic       blank_lz = 1'b0;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, dp = '0;
    logic [6:0] seg;
    logic       dpo;
    logic [3:0] an;
    logic       frame;

    bcd_scan_display #(
        .PRESCALE(P),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rn(rn), .ce(ce), .blank_lz(blank_lz),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp(dp),
        .seg(seg), .dpo(dpo), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fr;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpo;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // reference model state: enabled-cycle position within a frame
    int         n;
    logic [3:0] snap[4];
    logic [3:0] sdp;
    exp_t       o;

    logic [6:0] lut[16];
    initial begin
        lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F;
        lut[4] = 7'h66; lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07;
        lut[8] = 7'h7F; lut[9] = 7'h6F;
        for (int i = 10; i < 16; i++) lut[i] = 7'h40;
    end

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
        sdp = 4'd0;
        o.fr = 1'b0; o.an = 4'hF; o.seg = 7'h7F; o.dpo = 1'b1;
    endtask

    task automatic model_step();
        exp_t e;
        int   s;
        bit   blk;
        if (!rn) begin
            model_reset();
            q.push_back(o);
            return;
        end
        s = n / P;
        e = o;
        e.fr = ce && (n == FR - 1);
        q.push_back(e);
        if (ce) begin
            blk = blank_lz && (s != 0);
            for (int j = s; j < 4; j++) if (snap[j] != 0) blk = 0;
            o.an  = ~(4'b0001 << s);
            o.seg = blk ? 7'h7F : ~lut[snap[s]];
            o.dpo = ~sdp[s];
            if (n == FR - 1) begin
                snap[0] = d0; snap[1] = d1; snap[2] = d2; snap[3] = d3;
                sdp = dp;
            end
            n = (n + 1) % FR;
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic b,
                       input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0,
                       input logic [3:0] p);
        @(negedge clk);
        rn = r; ce = c; blank_lz = b;
        d3 = a3; d2 = a2; d1 = a1; d0 = a0; dp = p;
        model_step();
    endtask

    function automatic logic [3:0] rdig();
        return ($urandom % 2) ? 4'd0 : 4'($urandom % 16);
    endfunction

    task automatic rnd(input int cnt, input logic cefix);
        for (int i = 0; i < cnt; i++)
            cyc(1'b1, cefix ? 1'b1 : (($urandom % 10) != 0),
                1'($urandom % 2), rdig(), rdig(), rdig(), rdig(),
                4'($urandom % 16));
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h required %h",
                     nm, $time, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard at %0t: no expected entry", $time);
            end else begin
                e = q.pop_front();
                chk("frame", int'(frame), int'(e.fr));
                chk("an", int'(an), int'(e.an));
                chk("seg", int'(seg), int'(e.seg));
                chk("dpo", int'(dpo), int'(e.dpo));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3 * FR) cyc(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0);
        for (int i = 0; i < 2 * FR; i++)
            cyc(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3,
                (i > FR) ? 4'd9 : 4'd4, 4'd0);
        repeat (2 * FR) cyc(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        repeat (2 * FR) cyc(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0);
        repeat (2 * FR) cyc(1'b1, 1'b1, 1'b1, 4'd0, 4'hC, 4'd0, 4'd0, 4'b0100);
        rnd(300, 1'b0);
        while (n / P != 2 || n % P != 1) rnd(1, 1'b1);
        repeat (20) cyc(1'b1, 1'b0, 1'b1, 4'd7, 4'd7, 4'd7, 4'd7, 4'hF);
        rnd(2 * FR, 1'b1);
        while (n / P != 3) rnd(1, 1'b1);
        rnd(1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 4'd8, 4'd8, 4'd8, 4'd8, 4'hF);
        rnd(3 * FR, 1'b1);
        rnd(200, 1'b0);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
